glitch_sequencer: RTL and testbench

Top-level glitch attempt controller that sits directly upstream of the target-reset stage. On `start` it requests a target reset via `reset_req`, which drives that stage's enable. It then tracks the target's active-low reset line through assertion and release. After release it waits a programmable number of clock cycles and emits a single glitch pulse of programmable width. One attempt runs per `start`; the host reads `busy`, `done` and `error` as status.

---
 rtl/glitch_sequencer_pkg.sv | 16 +
 rtl/glitch_sequencer_if.sv | 23 ++
 rtl/glitch_sequencer.sv | 103 ++++++++++
 tb/tb_glitch_sequencer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/glitch_sequencer_pkg.sv
// glitch_sequencer_pkg: shared glitch definitions: sequencer state encodings and defaults.
package glitch_sequencer_pkg;
  typedef enum logic [2:0] {
    GLITCH_SEQ_IDLE      = 3'd0,
    GLITCH_SEQ_REQ       = 3'd1,
    GLITCH_SEQ_WAIT_LOW  = 3'd2,
    GLITCH_SEQ_WAIT_HIGH = 3'd3,
    GLITCH_SEQ_DELAY     = 3'd4,
    GLITCH_SEQ_GLITCH    = 3'd5,
    GLITCH_SEQ_FIN       = 3'd6
  } seq_state_e;
  localparam int RST_TIMEOUT_DEF = 64;
  function automatic int max3(int a, int b, int c);
    return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
  endfunction
endpackage

// File: rtl/glitch_sequencer_if.sv
// glitch_sequencer_if: host command/status bus of the glitch sequencer.
interface glitch_sequencer_if #(
  parameter int DELAY_W = 16,
  parameter int WIDTH_W = 8
);
  logic               start;
  logic               abort;
  logic [DELAY_W-1:0] delay;
  logic [WIDTH_W-1:0] width;
  logic               reset_req;
  logic               glitch_o;
  logic               busy;
  logic               done;
  logic               error;
  modport master (
    output start, abort, delay, width,
    input  reset_req, glitch_o, busy, done, error
  );
  modport slave (
    input  start, abort, delay, width,
    output reset_req, glitch_o, busy, done, error
  );
endinterface

// File: rtl/glitch_sequencer.sv
// glitch_sequencer: requests a target reset, tracks its release, then emits one timed glitch pulse.
module glitch_sequencer
  import glitch_sequencer_pkg::*;
#(
  parameter int DELAY_W     = 16,
  parameter int WIDTH_W     = 8,
  parameter int RST_TIMEOUT = RST_TIMEOUT_DEF
) (
  input logic               clk_in,
  input logic               rst,
  input logic               target_rst_n,
  glitch_sequencer_if.slave bus
);
  localparam int CNT_W = max3(DELAY_W, WIDTH_W, $clog2(RST_TIMEOUT)) + 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(RST_TIMEOUT - 1);
  seq_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, w_last;
  logic [DELAY_W-1:0] delay_q, delay_d;
  logic [WIDTH_W-1:0] width_q, width_d;
  logic               to_err;
  logic               reset_req_q, reset_req_d, glitch_q, glitch_d;
  logic               busy_q, busy_d, done_q, done_d, error_q, error_d;
  assign w_last = (width_q == '0) ? '0 : CNT_W'(width_q) - CNT_W'(1);
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q     <= GLITCH_SEQ_IDLE;
      cnt_q       <= '0;
      delay_q     <= '0;
      width_q     <= '0;
      reset_req_q <= 1'b0;
      glitch_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      delay_q     <= delay_d;
      width_q     <= width_d;
      reset_req_q <= reset_req_d;
      glitch_q    <= glitch_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    delay_d = delay_q;
    width_d = width_q;
    to_err  = 1'b0;
    case (state_q)
      GLITCH_SEQ_IDLE: if (bus.start) begin
        state_d = GLITCH_SEQ_REQ;
        delay_d = bus.delay;
        width_d = bus.width;
      end
      GLITCH_SEQ_REQ: begin
        state_d = GLITCH_SEQ_WAIT_LOW;
        cnt_d   = '0;
      end
      GLITCH_SEQ_WAIT_LOW: if (!target_rst_n) begin
        state_d = GLITCH_SEQ_WAIT_HIGH;
        cnt_d   = '0;
      end else if (cnt_q == TO_LAST) begin
        state_d = GLITCH_SEQ_IDLE;
        to_err  = 1'b1;
      end else cnt_d = cnt_q + CNT_W'(1);
      GLITCH_SEQ_WAIT_HIGH: if (target_rst_n) begin
        state_d = GLITCH_SEQ_DELAY;
        cnt_d   = '0;
      end else if (cnt_q == TO_LAST) begin
        state_d = GLITCH_SEQ_IDLE;
        to_err  = 1'b1;
      end else cnt_d = cnt_q + CNT_W'(1);
      // target_rst_n is deliberately ignored from here on: timing is committed at release
      GLITCH_SEQ_DELAY: if (cnt_q == CNT_W'(delay_q)) begin
        state_d = GLITCH_SEQ_GLITCH;
        cnt_d   = '0;
      end else cnt_d = cnt_q + CNT_W'(1);
      GLITCH_SEQ_GLITCH: if (cnt_q == w_last) state_d = GLITCH_SEQ_FIN;
        else cnt_d = cnt_q + CNT_W'(1);
      default: state_d = GLITCH_SEQ_IDLE;
    endcase
    if (bus.abort && state_q != GLITCH_SEQ_IDLE) begin
      state_d = GLITCH_SEQ_IDLE;
      to_err  = 1'b0;
    end
  end
  always_comb begin
    reset_req_d = state_d == GLITCH_SEQ_REQ;
    glitch_d    = state_d == GLITCH_SEQ_GLITCH;
    busy_d      = state_d != GLITCH_SEQ_IDLE;
    done_d      = state_d == GLITCH_SEQ_FIN;
    error_d     = to_err;
  end
  assign bus.reset_req = reset_req_q;
  assign bus.glitch_o  = glitch_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.error     = error_q;
endmodule

// File: tb/tb_glitch_sequencer.sv
// tb_glitch_sequencer: schedule-based reference model plus directed attempts with literal timing checks.
module tb_glitch_sequencer;
  localparam int TO = 64;
  logic clk_in = 1'b0;
  logic rst = 1'b1;
  logic target_rst_n = 1'b1;
  int   checks = 0;
  int   passes = 0;
  glitch_sequencer_if #(.DELAY_W(16), .WIDTH_W(8)) bus ();
  glitch_sequencer #(.DELAY_W(16), .WIDTH_W(8), .RST_TIMEOUT(TO)) dut (
    .clk_in(clk_in), .rst(rst), .target_rst_n(target_rst_n), .bus(bus)
  );
  always #5 clk_in = ~clk_in;
  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask
  // reset stage model: 0 = pulls low 9 cycles per request, 1 = stuck high, 2 = stuck low
  int rs_mode = 0;
  int rs_left = 0;
  always @(posedge clk_in) begin
    #1;
    if (rs_mode == 1) target_rst_n = 1'b1;
    else if (rs_mode == 2) target_rst_n = 1'b0;
    else begin
      if (bus.reset_req) rs_left = 9;
      if (rs_left > 0) begin
        target_rst_n = 1'b0;
        rs_left--;
      end else target_rst_n = 1'b1;
    end
  end
  // model: phase plus absolute edge timestamps; once released the whole pulse is a fixed schedule
  longint cyc = 0, tref = 0, rel = 0, md = 0, mw = 1;
  int     ph = 0;
  logic   e_req = 0, e_gl = 0, e_busy = 0, e_done = 0, e_err = 0;
  always @(posedge clk_in) begin
    cyc++;
    e_err = 1'b0;
    if (rst) ph = 0;
    else if (bus.abort && ph != 0) ph = 0;
    else case (ph)
      0: if (bus.start) begin
        ph = 1;
        md = longint'(bus.delay);
        mw = (bus.width == 0) ? 1 : longint'(bus.width);
      end
      1: begin ph = 2; tref = cyc; end
      2: if (!target_rst_n) begin ph = 3; tref = cyc; end
         else if (cyc - tref >= TO) begin ph = 0; e_err = 1'b1; end
      3: if (target_rst_n) begin ph = 4; rel = cyc; end
         else if (cyc - tref >= TO) begin ph = 0; e_err = 1'b1; end
      default: if (cyc >= rel + md + mw + 2) ph = 0;
    endcase
    e_req  = ph == 1;
    e_busy = ph != 0;
    e_gl   = ph == 4 && cyc >= rel + md + 1 && cyc <= rel + md + mw;
    e_done = ph == 4 && cyc == rel + md + mw + 1;
  end
  longint q_req[$], q_gl[$], q_busy[$], q_done[$], q_err[$];
  always @(negedge clk_in) if (cyc > 0) begin
    chk("cycle {req,glitch,busy,done,error}",
        longint'({bus.reset_req, bus.glitch_o, bus.busy, bus.done, bus.error}),
        longint'({e_req, e_gl, e_busy, e_done, e_err}));
    if (bus.reset_req) q_req.push_back(cyc);
    if (bus.glitch_o) q_gl.push_back(cyc);
    if (bus.busy) q_busy.push_back(cyc);
    if (bus.done) q_done.push_back(cyc);
    if (bus.error) q_err.push_back(cyc);
  end
  function automatic longint n_after(input longint q[$], input longint m);
    longint n = 0;
    foreach (q[i]) if (q[i] > m) n++;
    return n;
  endfunction
  function automatic longint first_after(input longint q[$], input longint m);
    foreach (q[i]) if (q[i] > m) return q[i];
    return -1;
  endfunction
  function automatic longint last_after(input longint q[$], input longint m);
    longint l = -1;
    foreach (q[i]) if (q[i] > m) l = q[i];
    return l;
  endfunction
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask
  task automatic launch(input logic [15:0] d, input logic [7:0] w);
    bus.start = 1'b1;
    bus.delay = d;
    bus.width = w;
    step();
    bus.start = 1'b0;
  endtask
  task automatic wait_end(input string name, input int lim);
    for (int i = 0; i < lim; i++) begin
      if (bus.done || bus.error) return;
      step();
    end
    chk({name, " end-of-attempt wait"}, 0, 1);
  endtask
  longint m;
  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.delay = '0;
    bus.width = '0;
    repeat (3) step();
    chk("reset outputs", longint'({bus.reset_req, bus.glitch_o, bus.busy, bus.done, bus.error}), 0);
    rst = 1'b0;
    step();
    // 1: nominal
    m = cyc;
    launch(16'd5, 8'd3);
    wait_end("nominal", 200);
    repeat (2) step();
    chk("nom req pulses", n_after(q_req, m), 1);
    chk("nom glitch cycles", n_after(q_gl, m), 3);
    chk("nom req->glitch", first_after(q_gl, m) - first_after(q_req, m), 16);
    chk("nom glitch->done", first_after(q_done, m) - first_after(q_gl, m), 3);
    chk("nom done pulses", n_after(q_done, m), 1);
    chk("nom busy last = done", last_after(q_busy, m), first_after(q_done, m));
    // 2: boundary arguments
    m = cyc;
    launch(16'd0, 8'd0);
    wait_end("d0w0", 200);
    repeat (2) step();
    chk("d0w0 glitch cycles", n_after(q_gl, m), 1);
    chk("d0w0 req->glitch", first_after(q_gl, m) - first_after(q_req, m), 11);
    m = cyc;
    launch(16'hffff, 8'hff);
    wait_end("dmax", 70000);
    repeat (2) step();
    chk("dmax glitch cycles", n_after(q_gl, m), 255);
    chk("dmax req->glitch", first_after(q_gl, m) - first_after(q_req, m), 65546);
    chk("dmax done pulses", n_after(q_done, m), 1);
    // 3: timeouts
    rs_mode = 1;
    m = cyc;
    launch(16'd1, 8'd1);
    wait_end("stuck high", 200);
    repeat (2) step();
    chk("stuck high req->error", first_after(q_err, m) - first_after(q_req, m), 65);
    chk("stuck high errors", n_after(q_err, m), 1);
    chk("stuck high glitch", n_after(q_gl, m), 0);
    chk("stuck high idle", longint'(bus.busy), 0);
    rs_mode = 2;
    m = cyc;
    launch(16'd1, 8'd1);
    wait_end("stuck low", 200);
    repeat (2) step();
    chk("stuck low req->error", first_after(q_err, m) - first_after(q_req, m), 66);
    chk("stuck low glitch", n_after(q_gl, m), 0);
    chk("stuck low done", n_after(q_done, m), 0);
    rs_mode = 0;
    repeat (2) step();
    // 4: abort during GLITCH
    m = cyc;
    launch(16'd2, 8'd10);
    for (int i = 0; i < 200 && !bus.glitch_o; i++) step();
    repeat (3) step();
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("abort glitch low", longint'(bus.glitch_o), 0);
    chk("abort busy low", longint'(bus.busy), 0);
    chk("abort glitch cycles", n_after(q_gl, m), 4);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("restart req", longint'(bus.reset_req), 1);
    wait_end("restart", 200);
    repeat (2) step();
    chk("abort no done", n_after(q_done, m), 1);
    // 5: start held while busy, with abort coincident in IDLE
    m = cyc;
    bus.start = 1'b1;
    bus.abort = 1'b1;
    bus.delay = 16'd3;
    bus.width = 8'd2;
    step();
    bus.abort = 1'b0;
    bus.delay = 16'd100;
    bus.width = 8'd50;
    wait_end("held start", 300);
    bus.start = 1'b0;
    repeat (3) step();
    chk("held req pulses", n_after(q_req, m), 1);
    chk("held glitch cycles", n_after(q_gl, m), 2);
    chk("held req->glitch", first_after(q_gl, m) - first_after(q_req, m), 14);
    chk("held idle after", longint'(bus.busy), 0);
    // 6: rst during DELAY
    m = cyc;
    launch(16'd20, 8'd4);
    repeat (14) step();
    chk("rst case in delay", longint'(bus.busy), 1);
    rst = 1'b1;
    step();
    chk("rst outputs", longint'({bus.reset_req, bus.glitch_o, bus.busy, bus.done, bus.error}), 0);
    rst = 1'b0;
    repeat (40) step();
    chk("rst no spurious req", n_after(q_req, m), 1);
    chk("rst no glitch", n_after(q_gl, m), 0);
    chk("rst idle", longint'(bus.busy), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
